// File: rtl/hexdisp_bank.sv
// Multi-digit hex seven-segment controller: bus-writable value/blank/ctrl registers,
// parallel active-low segment outputs and a registered time-multiplexed scan output.
module hexdisp_bank #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [1:0]            adr_i,
  input  logic [31:0]           dat_i,
  output logic [31:0]           dat_o,
  output logic                  ack_o,
  output logic [7*DIGITS-1:0]   segs_o,
  output logic [6:0]            scan_seg_o,
  output logic [DIGITS-1:0]     scan_an_o
);

  localparam int unsigned VW   = 4 * DIGITS;
  localparam int unsigned PtrW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [VW-1:0]          value_q, value_d;
  logic [DIGITS-1:0]      blank_q, blank_d;
  logic [1:0]             ctrl_q, ctrl_d;
  logic                   ack_q, ack_d;
  logic [31:0]            dat_q, dat_d;
  logic [7*DIGITS-1:0]    segs_q, segs_c;
  logic [6:0]             scan_seg_q, scan_seg_d;
  logic [DIGITS-1:0]      scan_an_q, scan_an_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [PtrW-1:0]        ptr_q, ptr_d;

  logic                   access;
  logic [31:0]            rdata;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // An access is accepted when strobed and not in its ack cycle: one access per two cycles.
  assign access = stb_i & ~ack_q;

  // Bus read mux and register write decode.
  always_comb begin
    rdata   = '0;
    value_d = value_q;
    blank_d = blank_q;
    ctrl_d  = ctrl_q;
    case (adr_i)
      2'd0:    rdata[VW-1:0]     = value_q;
      2'd1:    rdata[DIGITS-1:0] = blank_q;
      2'd2:    rdata[1:0]        = ctrl_q;
      default: rdata             = '0;
    endcase
    if (access && we_i) begin
      case (adr_i)
        2'd0:    value_d = dat_i[VW-1:0];
        2'd1:    blank_d = dat_i[DIGITS-1:0];
        2'd2:    ctrl_d  = dat_i[1:0];
        default: ;
      endcase
    end
    ack_d = access;
    dat_d = (access && !we_i) ? rdata : '0;
  end

  // Per-digit decode with blanking and leading-zero suppression on raw nibbles.
  always_comb begin
    logic zero_above;
    logic dark;
    logic [3:0] nib;
    segs_c     = '0;
    zero_above = 1'b1;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      nib        = value_q[4*k +: 4];
      zero_above = zero_above & (nib == 4'h0);
      dark       = ~ctrl_q[1] | blank_q[k] | (ctrl_q[0] & (k > 0) & zero_above);
      segs_c[7*k +: 7] = dark ? 7'h7F : hex_decode(nib);
    end
  end

  // Refresh counter, digit pointer and next scan outputs from the current registers.
  always_comb begin
    logic wrap;
    wrap  = (cnt_q == CntW'(REFRESH_DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    ptr_d = ptr_q;
    if (wrap) begin
      ptr_d = (ptr_q == PtrW'(DIGITS - 1)) ? '0 : ptr_q + 1'b1;
    end
    scan_seg_d = 7'h7F;
    scan_an_d  = '1;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (ptr_q == PtrW'(k)) begin
        scan_seg_d   = segs_c[7*k +: 7];
        scan_an_d[k] = ~ctrl_q[1];
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q    <= '0;
      blank_q    <= '0;
      ctrl_q     <= 2'b10;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      segs_q     <= '1;
      scan_seg_q <= 7'h7F;
      scan_an_q  <= '1;
      cnt_q      <= '0;
      ptr_q      <= '0;
    end else begin
      value_q    <= value_d;
      blank_q    <= blank_d;
      ctrl_q     <= ctrl_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      segs_q     <= segs_c;
      scan_seg_q <= scan_seg_d;
      scan_an_q  <= scan_an_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  assign dat_o      = dat_q;
  assign ack_o      = ack_q;
  assign segs_o     = segs_q;
  assign scan_seg_o = scan_seg_q;
  assign scan_an_o  = scan_an_q;

endmodule

// File: tb/tb_hexdisp_bank.sv
// Directed bench for hexdisp_bank with DIGITS=4, REFRESH_DIV=3.
module tb_hexdisp_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb;
  logic        we;
  logic [1:0]  adr;
  logic [31:0] dat_in;
  logic [31:0] dat_out;
  logic        ack;
  logic [27:0] segs;
  logic [6:0]  scan_seg;
  logic [3:0]  scan_an;

  int checks = 0;
  int errors = 0;

  hexdisp_bank #(.DIGITS(4), .REFRESH_DIV(3)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .stb_i      (stb),
    .we_i       (we),
    .adr_i      (adr),
    .dat_i      (dat_in),
    .dat_o      (dat_out),
    .ack_o      (ack),
    .segs_o     (segs),
    .scan_seg_o (scan_seg),
    .scan_an_o  (scan_an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = a; dat_in = d;
    @(negedge clk);
    check("wr_ack", 32'(ack), 32'd1);
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check("wr_ack_drop", 32'(ack), 32'd0);
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    stb = 1'b1; we = 1'b0; adr = a;
    @(negedge clk);
    check("rd_ack", 32'(ack), 32'd1);
    check(tag, dat_out, exp);
    stb = 1'b0;
  endtask

  initial begin
    logic [3:0]  exp_an [5];
    logic [6:0]  exp_seg [5];
    logic        found;
    int          acks;

    rst = 1'b1; stb = 1'b0; we = 1'b0; adr = '0; dat_in = '0;
    repeat (3) @(negedge clk);
    check("rst_segs", 32'(segs), 32'h0FFFFFFF);
    check("rst_scan_seg", 32'(scan_seg), 32'h7F);
    check("rst_scan_an", 32'(scan_an), 32'hF);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dat", dat_out, 32'd0);

    rst = 1'b0;
    @(negedge clk);
    check("post_rst_segs", 32'(segs), 32'h08102040);
    check("post_rst_an", 32'(scan_an), 32'hE);
    check("post_rst_ack", 32'(ack), 32'd0);

    // Value write and readback: digits 3..0 = A,b,C,d.
    bus_write(2'd0, 32'h0000ABCD);
    check("segs_abcd", 32'(segs), 32'({7'h08, 7'h03, 7'h46, 7'h21}));
    bus_read(2'd0, 32'h0000ABCD, "rd_value");

    // Scan sequence: sync on digit 3, then step every 3 cycles.
    exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    exp_seg = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h21};
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk);
      if (scan_an == 4'b0111) found = 1'b1;
    end
    check("scan_sync", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (scan_an != 4'b0111) found = 1'b1;
    end
    check("scan_change", 32'(found), 32'd1);
    check("scan_an_0", 32'(scan_an), 32'(exp_an[0]));
    check("scan_seg_0", 32'(scan_seg), 32'(exp_seg[0]));
    for (int s = 1; s < 5; s++) begin
      repeat (2) @(negedge clk);
      check("scan_hold", 32'(scan_an), 32'(exp_an[s-1]));
      @(negedge clk);
      check("scan_an_step", 32'(scan_an), 32'(exp_an[s]));
      check("scan_seg_step", 32'(scan_seg), 32'(exp_seg[s]));
    end

    // Leading-zero suppression.
    bus_write(2'd0, 32'h00000050);
    bus_write(2'd2, 32'h00000003);
    check("lzs_0050", 32'(segs), 32'({7'h7F, 7'h7F, 7'h12, 7'h40}));
    bus_write(2'd0, 32'h00000000);
    check("lzs_zero", 32'(segs), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

    // Blank mask; unused high data bits are dropped.
    bus_write(2'd1, 32'hFFFFFFF0);
    bus_read(2'd1, 32'h0, "rd_blank_hi");
    bus_write(2'd1, 32'h00000005);
    bus_write(2'd2, 32'h00000002);
    check("blank_0101", 32'(segs), 32'({7'h40, 7'h7F, 7'h40, 7'h7F}));
    bus_read(2'd1, 32'h5, "rd_blank");
    bus_write(2'd2, 32'h00000000);
    check("disp_off_segs", 32'(segs), 32'h0FFFFFFF);
    repeat (4) begin
      @(negedge clk);
      check("disp_off_an", 32'(scan_an), 32'hF);
    end
    bus_read(2'd2, 32'h0, "rd_ctrl");

    // Reserved address.
    bus_write(2'd3, 32'hFFFFFFFF);
    bus_read(2'd3, 32'h0, "rd_rsvd");
    bus_read(2'd1, 32'h5, "rd_blank_after_rsvd");

    // Continuous strobe: one ack per two cycles.
    bus_write(2'd0, 32'h00001234);
    @(negedge clk);
    stb = 1'b1; we = 1'b0; adr = 2'd0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("burst_acks", 32'(acks), 32'd3);
    rst = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("rst_mid_acks", 32'(acks), 32'd0);
    stb = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    bus_read(2'd0, 32'h0, "rst_value");
    bus_read(2'd1, 32'h0, "rst_blank");
    bus_read(2'd2, 32'h2, "rst_ctrl");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hexdisp_bank.md
# hexdisp_bank

Multi-digit hexadecimal seven-segment display controller and generalised successor to the single-digit hex decoder. It holds a display value, a per-digit blank mask and a control word in bus-writable registers. It drives every digit in parallel for boards with discrete displays, and also drives a time-multiplexed scan output for boards with common-anode digit muxing. It sits on the I/O bus next to the other FPGA peripherals.

## Interface
- DIGITS, 8, number of hex digits; legal range 1..8.
- REFRESH_DIV, 50000, clock cycles each digit stays selected in scan mode; must be ≥ 1.
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- stb_i  in  1  bus strobe; a cycle is in progress.
- we_i  in  1  1 = write, 0 = read; qualified by stb_i.
- adr_i  in  2  register select: 0 = value, 1 = blank mask, 2 = control, 3 = reserved.
- dat_i  in  32  write data.
- dat_o  out  32  read data; valid while ack_o = 1.
- ack_o  out  1  single-cycle bus acknowledge.
- segs_o  out  7*DIGITS  parallel segments, active-low; bits [7k+6:7k] belong to digit k, with bit order g,f,e,d,c,b,a (MSB to LSB).
- scan_seg_o  out  7  segments of the currently scanned digit, active-low.
- scan_an_o  out  DIGITS  digit enables, active-low, one-hot-low.

## Operation
- Registers:
  - value[4*DIGITS-1:0]: digit k is nibble k.
  - blank[DIGITS-1:0]: bit k = 1 forces digit k dark.
  - ctrl[1:0]: bit0 = leading-zero suppression (LZS) enable, bit1 = display enable.
- Reset values: value = 0, blank = 0, ctrl = 2'b10 (display on, LZS off).
- Register writes:
  - Unused high bits of dat_i are ignored.
  - Writes to adr 3 are acknowledged and have no effect.
- Register reads:
  - Return the register zero-extended to 32 bits.
  - adr 3 reads 0.
- Decode, active-low, gfedcba: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h, A=08h, b=03h, C=46h, d=21h, E=06h, F=0Eh. Dark digit = 7Fh.
- Digit k is dark if any of the following holds:
  - ctrl[1] = 0;
  - blank[k] = 1;
  - LZS is on, k > 0, and every nibble from k up to DIGITS-1 is zero.
- Digit 0 is never suppressed by LZS. Value 0 with LZS on shows a single "0".
- LZS is evaluated on raw nibbles, independent of the blank mask.
- Scan engine:
  - A refresh counter runs 0..REFRESH_DIV-1.
  - When the counter wraps, the digit pointer ptr advances ptr → (ptr+1) mod DIGITS. Wrap-around from DIGITS-1 goes to 0.
  - With DIGITS = 1, ptr stays at 0.
  - scan_an_o = ~(1<<ptr) and scan_seg_o = segs_o digit ptr. Both are registered and updated on the same edge, so no ghosting occurs.
  - While ctrl[1] = 0, scan_an_o is all ones; the counter and ptr keep running.

## Timing
- Bus handshake:
  - ack_o rises in the cycle after stb_i is sampled high with ack_o low.
  - ack_o lasts exactly one cycle.
  - If stb_i stays high, the next ack follows two cycles later, giving one access per two cycles.
- Write timing:
  - A write is committed on the edge that sets ack_o (edge E).
  - segs_o reflects the write at edge E+1.
  - scan outputs reflect it at edge E+1 if that digit is selected.
- Read data is sampled on edge E and is valid with ack_o.
- During reset and at the first edge with rst_i high, outputs are:
  - segs_o: all ones;
  - scan_seg_o: 7Fh;
  - scan_an_o: all ones;
  - ack_o: 0;
  - dat_o: 0;
  - counter: 0;
  - ptr: 0.
- Reset mid-cycle: a pending access is dropped with no ack, and registers return to their reset values.
- First edge after reset is released:
  - segs_o = 40h for digit 0;
  - the other digits show 40h as well, because LZS is off;
  - scan_an_o selects digit 0.
- A write landing on the same edge as a scan advance: the new ptr and the new data are both used at the following edge.

## Test plan
- Reset, DIGITS=4 → segs_o = 28'h8102040 (four 40h digits), scan_an_o = 4'b1110, ack_o = 0.
- Write adr 0 = 32'h0000ABCD, stb for 1 cycle → ack_o high exactly 1 cycle; 1 cycle later segs_o digits 3..0 = 08h, 03h, 46h, 21h. Read adr 0 → dat_o = 0000ABCDh.
- value = 0x0050, ctrl = 2'b11 (LZS on) → digits 3,2 = 7Fh, digit 1 = 12h, digit 0 = 40h. Then value = 0 → only digit 0 lit (40h).
- blank = 4'b0101, ctrl = 2'b10 → digits 0 and 2 = 7Fh. Then ctrl = 0 → all digits 7Fh and scan_an_o = 4'b1111.
- REFRESH_DIV = 3, DIGITS = 4 → scan_an_o steps 1110, 1101, 1011, 0111, 1110 every 3 cycles, with scan_seg_o matching the selected digit on each step.
- stb_i held high for 6 cycles with we_i = 0 → exactly 3 ack pulses. Assert rst_i mid-stream → no further ack, and registers return to reset values.
